gate_access_ctrl: RTL and testbench



---
 rtl/gate_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 38 +++
 rtl/gate_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_gate_access_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared types and widths for the entrance gate controller.
// State encoding plus digit, code and countdown widths.
package gate_pkg;

    localparam int DIGIT_W = 4;
    localparam int CODE_W  = 16;
    localparam int CNT_W   = 6;
    localparam int DCNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        LOCKOUT
    } gate_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick divider with clear and hold.
// tick is high while the counter sits on its last value.
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_access_ctrl.sv
// Keypad-driven gate sequencer: code entry, timed open window,
// gateway-occupied extension and wrong-code lockout.
module gate_access_ctrl
    import gate_pkg::*;
#(
    parameter logic [15:0] PASS_CODE   = 16'hA5C3,
    parameter int          TICK_DIV    = 100000,
    parameter int          OPEN_TICKS  = 10,
    parameter int          LOCK_TICKS  = 30,
    parameter int          MAX_FAILS   = 3,
    parameter int          ENTRY_TICKS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               ir_gate,
    output logic               gate_open,
    output logic               corridor_light,
    output logic               locked,
    output logic [CNT_W-1:0]   seconds_remaining,
    output logic [DCNT_W-1:0]  digits_entered,
    output logic [1:0]         fail_count
);

    localparam logic [CNT_W-1:0] OPEN_CNT  = CNT_W'(OPEN_TICKS);
    localparam logic [CNT_W-1:0] LOCK_CNT  = CNT_W'(LOCK_TICKS);
    localparam logic [CNT_W-1:0] ENTRY_CNT = CNT_W'(ENTRY_TICKS);
    localparam logic [1:0]       FAIL_LAST = 2'(MAX_FAILS - 1);

    gate_state_e         state_q;
    logic [CODE_W-1:0]   code_q;
    logic [DCNT_W-1:0]   digits_q;
    logic [1:0]          fails_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    sec_q;
    logic                gate_q;
    logic                light_q;
    logic                lock_q;

    logic key_acc;
    logic hold;
    logic clear;
    logic tick;
    logic tick_en;

    assign key_acc = key_valid && (state_q == IDLE || state_q == ENTRY);
    assign hold    = (state_q == OPEN) && ir_gate;
    // IDLE and CHECK always leave via a fresh window, so keep it zeroed there
    assign clear   = key_acc || state_q == IDLE || state_q == CHECK;
    assign tick_en = tick && !hold;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .hold (hold),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            code_q   <= '0;
            digits_q <= '0;
            fails_q  <= '0;
            cnt_q    <= '0;
            sec_q    <= '0;
            gate_q   <= 1'b0;
            light_q  <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        code_q   <= {code_q[11:0], key_digit};
                        digits_q <= 3'd1;
                        cnt_q    <= ENTRY_CNT;
                        sec_q    <= ENTRY_CNT;
                        light_q  <= 1'b1;
                        state_q  <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (key_valid) begin
                        code_q <= {code_q[11:0], key_digit};
                        if (digits_q == 3'd3) begin
                            digits_q <= 3'd4;
                            cnt_q    <= '0;
                            sec_q    <= '0;
                            state_q  <= CHECK;
                        end else begin
                            digits_q <= digits_q + 3'd1;
                            cnt_q    <= ENTRY_CNT;
                            sec_q    <= ENTRY_CNT;
                        end
                    end else if (tick_en) begin
                        if (cnt_q == 6'd1) begin
                            code_q   <= '0;
                            digits_q <= '0;
                            cnt_q    <= '0;
                            sec_q    <= '0;
                            light_q  <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 6'd1;
                            sec_q <= cnt_q - 6'd1;
                        end
                    end
                end
                CHECK: begin
                    digits_q <= '0;
                    code_q   <= '0;
                    if (code_q == PASS_CODE) begin
                        fails_q <= '0;
                        cnt_q   <= OPEN_CNT;
                        sec_q   <= OPEN_CNT;
                        gate_q  <= 1'b1;
                        state_q <= OPEN;
                    end else if (fails_q == FAIL_LAST) begin
                        cnt_q   <= LOCK_CNT;
                        sec_q   <= LOCK_CNT;
                        lock_q  <= 1'b1;
                        light_q <= 1'b0;
                        state_q <= LOCKOUT;
                    end else begin
                        fails_q <= fails_q + 2'd1;
                        light_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                OPEN: begin
                    if (tick_en) begin
                        if (cnt_q == 6'd1) begin
                            cnt_q   <= '0;
                            sec_q   <= '0;
                            gate_q  <= 1'b0;
                            light_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 6'd1;
                            sec_q <= cnt_q - 6'd1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (tick_en) begin
                        if (cnt_q == 6'd1) begin
                            cnt_q   <= '0;
                            sec_q   <= '0;
                            fails_q <= '0;
                            lock_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 6'd1;
                            sec_q <= cnt_q - 6'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gate_open         = gate_q;
    assign corridor_light    = light_q;
    assign locked            = lock_q;
    assign seconds_remaining = sec_q;
    assign digits_entered    = digits_q;
    assign fail_count        = fails_q;

endmodule

// File: tb/tb_gate_access_ctrl.sv
// Directed bench for gate_access_ctrl: vector table for the
// open sequence, hand-written sequences for the timed corners.
module tb_gate_access_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'h0;
    logic       ir_gate = 1'b0;
    logic       gate_open;
    logic       corridor_light;
    logic       locked;
    logic [5:0] seconds_remaining;
    logic [2:0] digits_entered;
    logic [1:0] fail_count;

    int total = 0;
    int bad   = 0;

    gate_access_ctrl #(
        .PASS_CODE  (16'hA5C3),
        .TICK_DIV   (4),
        .OPEN_TICKS (3),
        .LOCK_TICKS (5),
        .MAX_FAILS  (3),
        .ENTRY_TICKS(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .key_valid        (key_valid),
        .key_digit        (key_digit),
        .ir_gate          (ir_gate),
        .gate_open        (gate_open),
        .corridor_light   (corridor_light),
        .locked           (locked),
        .seconds_remaining(seconds_remaining),
        .digits_entered   (digits_entered),
        .fail_count       (fail_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       kv;
        logic [3:0] kd;
        logic       ir;
        logic       go;
        logic       cl;
        logic       lk;
        logic [5:0] sec;
        logic [2:0] dig;
        logic [1:0] fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic kv, logic [3:0] kd,
                                logic ir, logic go, logic cl, logic lk,
                                logic [5:0] sec, logic [2:0] dig,
                                logic [1:0] fc);
        vec_t v;
        v.rst = rst; v.kv = kv; v.kd = kd; v.ir = ir;
        v.go = go; v.cl = cl; v.lk = lk;
        v.sec = sec; v.dig = dig; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input vec_t v);
        chk({nm, ".gate"}, int'(gate_open), int'(v.go));
        chk({nm, ".light"}, int'(corridor_light), int'(v.cl));
        chk({nm, ".locked"}, int'(locked), int'(v.lk));
        chk({nm, ".sec"}, int'(seconds_remaining), int'(v.sec));
        chk({nm, ".digits"}, int'(digits_entered), int'(v.dig));
        chk({nm, ".fails"}, int'(fail_count), int'(v.fc));
    endtask

    task automatic apply(input vec_t v, input string nm);
        reset = v.rst; key_valid = v.kv; key_digit = v.kd; ir_gate = v.ir;
        @(posedge clk); #1;
        reset = 1'b0; key_valid = 1'b0;
        chk_out(nm, v);
    endtask

    task automatic cyc(input logic kv, input logic [3:0] kd);
        key_valid = kv; key_digit = kd;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic code4(input logic [15:0] c);
        for (int i = 0; i < 4; i++) cyc(1'b1, c[15-4*i -: 4]);
    endtask

    task automatic rst_cycle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_gate(output int n);
        n = 1;
        while (gate_open && n < 100) begin
            cyc(1'b0, 4'h0);
            if (gate_open) n++;
        end
    endtask

    vec_t zero_v;
    int   n;
    logic ok;
    logic [5:0] sec_prev;

    initial begin
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'hA, 0, 0, 1, 0, 2, 1, 0));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, 1, 0, 2, 2, 0));
        tbl.push_back(mk(0, 1, 4'hC, 0, 0, 1, 0, 2, 3, 0));
        tbl.push_back(mk(0, 1, 4'h3, 0, 0, 1, 0, 0, 4, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 3, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("open[%0d]", i));

        // lockout after three wrong codes
        code4(16'h1234); cyc(0, 0);
        chk("lock.fc1", int'(fail_count), 1);
        chk("lock.light_off", int'(corridor_light), 0);
        code4(16'h1234); cyc(0, 0);
        chk("lock.fc2", int'(fail_count), 2);
        code4(16'h1234); cyc(0, 0);
        chk("lock.locked", int'(locked), 1);
        chk("lock.sec", int'(seconds_remaining), 5);
        n = 1; ok = 1'b1;
        while (locked && n < 100) begin
            cyc(1'b1, 4'hA);
            if (digits_entered != 3'd0) ok = 1'b0;
            if (locked) n++;
        end
        chk("lock.len", n, 20);
        chk("lock.keys_ignored", int'(ok), 1);
        chk("lock.fc_clear", int'(fail_count), 0);
        code4(16'hA5C3); cyc(0, 0);
        chk("lock.reopen", int'(gate_open), 1);
        wait_gate(n);
        chk("lock.reopen_len", n, 12);

        // entry timeout keeps fail_count
        code4(16'h1111); cyc(0, 0);
        chk("tmo.fc_pre", int'(fail_count), 1);
        cyc(1, 4'hA); cyc(1, 4'h5);
        n = 0;
        while (digits_entered != 3'd0 && n < 50) begin
            cyc(0, 0);
            n++;
        end
        chk("tmo.len", n, 8);
        chk("tmo.fc", int'(fail_count), 1);
        chk("tmo.light", int'(corridor_light), 0);
        code4(16'hA5C3); cyc(0, 0);
        chk("tmo.open", int'(gate_open), 1);
        chk("tmo.fc_clr", int'(fail_count), 0);
        wait_gate(n);

        // gateway hold for 10 cycles
        code4(16'hA5C3); cyc(0, 0);
        chk("hold.open", int'(gate_open), 1);
        n = 1; ok = 1'b1;
        while (gate_open && n < 100) begin
            ir_gate = (n >= 3 && n < 13);
            sec_prev = seconds_remaining;
            cyc(0, 0);
            if (ir_gate && seconds_remaining != sec_prev) ok = 1'b0;
            if (gate_open) n++;
        end
        ir_gate = 1'b0;
        chk("hold.len", n, 22);
        chk("hold.frozen", int'(ok), 1);

        // one wrong code is forgiven by a correct one
        code4(16'h9999); cyc(0, 0);
        chk("fclr.fc1", int'(fail_count), 1);
        code4(16'hA5C3); cyc(0, 0);
        chk("fclr.open", int'(gate_open), 1);
        chk("fclr.fc0", int'(fail_count), 0);
        wait_gate(n);
        code4(16'h9999); cyc(0, 0);
        code4(16'h9999); cyc(0, 0);
        chk("fclr.fc2", int'(fail_count), 2);
        chk("fclr.nolock", int'(locked), 0);

        // reset mid-OPEN
        rst_cycle();
        code4(16'hA5C3); cyc(0, 0); cyc(0, 0); cyc(0, 0);
        chk("rst.pre_open", int'(gate_open), 1);
        rst_cycle();
        chk_out("rst.open", zero_v);

        // reset mid-LOCKOUT
        for (int k = 0; k < 3; k++) begin
            code4(16'h4321); cyc(0, 0);
        end
        cyc(0, 0);
        chk("rst.pre_lock", int'(locked), 1);
        rst_cycle();
        chk_out("rst.lock", zero_v);

        // partial code is discarded by reset
        cyc(1, 4'hA); cyc(1, 4'h5);
        rst_cycle();
        chk("rst.partial", int'(digits_entered), 0);
        cyc(1, 4'hC); cyc(1, 4'h3);
        chk("rst.after_dig", int'(digits_entered), 2);
        chk("rst.after_light", int'(corridor_light), 1);
        rst_cycle();

        // key coinciding with an entry tick wins
        cyc(1, 4'hA);
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        chk("coin.pre_sec", int'(seconds_remaining), 2);
        cyc(1, 4'h5);
        chk("coin.dig", int'(digits_entered), 2);
        chk("coin.sec", int'(seconds_remaining), 2);
        cyc(1, 4'hC); cyc(1, 4'h3); cyc(0, 0);
        chk("coin.open", int'(gate_open), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
